acc_drain_quant: RTL and testbench



---
 rtl/acc_drain_quant_pkg.sv | 42 ++++
 rtl/acc_drain_quant_requant_lane.sv | 50 +++++
 rtl/acc_drain_quant.sv | 138 +++++++++++++
 tb/tb_acc_drain_quant.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_drain_quant_pkg.sv
// Shared widths, saturation limits and FSM encoding for the accumulator drain.
// Imported by the drain top and its per-lane requantizer.
package acc_drain_quant_pkg;

    localparam int ARRAY_COL   = 16;
    localparam int ACC_WIDTH   = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int OUT_WIDTH   = 8;
    localparam int SCALE_WIDTH = 16;
    localparam int SHIFT_WIDTH = 5;

    localparam int PROD_WIDTH = ACC_WIDTH + SCALE_WIDTH;
    // Two guard bits cover the rounding add and the zero-point add.
    localparam int WIDE_WIDTH = PROD_WIDTH + 2;

    localparam logic [OUT_WIDTH-1:0] OUT_MAX = 8'h7f;
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = 8'h80;

    localparam logic signed [WIDE_WIDTH-1:0] WIDE_MAX = WIDE_WIDTH'(127);
    localparam logic signed [WIDE_WIDTH-1:0] WIDE_MIN = WIDE_WIDTH'(-128);
    localparam logic [WIDE_WIDTH-1:0] WIDE_ONE = WIDE_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH
    } state_e;

    function automatic logic [OUT_WIDTH-1:0] sat_out(
        input logic signed [WIDE_WIDTH-1:0] v
    );
        logic [OUT_WIDTH-1:0] r;
        r = v[OUT_WIDTH-1:0];
        if (v > WIDE_MAX) begin
            r = OUT_MAX;
        end else if (v < WIDE_MIN) begin
            r = OUT_MIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_drain_quant_requant_lane.sv
// One requantization lane: registered product, then registered
// round-shift, zero-point add and INT8 saturation; both hold when en_i is low.
module requant_lane
    import acc_drain_quant_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [SCALE_WIDTH-1:0] scale_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic [OUT_WIDTH-1:0]   zp_i,
    output logic [OUT_WIDTH-1:0]   q_o
);

    logic signed [PROD_WIDTH-1:0] prod_d;
    logic signed [PROD_WIDTH-1:0] prod_q;
    logic signed [WIDE_WIDTH-1:0] rnd;
    logic signed [WIDE_WIDTH-1:0] wide;
    logic signed [WIDE_WIDTH-1:0] shifted;
    logic signed [WIDE_WIDTH-1:0] biased;
    logic [OUT_WIDTH-1:0]         q_d;
    logic [OUT_WIDTH-1:0]         q_q;

    always_comb begin
        prod_d = PROD_WIDTH'($signed(acc_i)) * PROD_WIDTH'($signed(scale_i));
        rnd = '0;
        // Half-LSB bias gives round-half-up; a zero shift passes p through.
        if (shift_i != '0) begin
            rnd = WIDE_ONE << (shift_i - SHIFT_WIDTH'(1));
        end
        wide    = WIDE_WIDTH'(prod_q) + rnd;
        shifted = wide >>> shift_i;
        biased  = shifted + WIDE_WIDTH'($signed(zp_i));
        q_d     = sat_out(biased);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            q_q    <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
            q_q    <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/acc_drain_quant.sv
// Accumulator bank drain: walks rows, requantizes 16 INT32 lanes to INT8
// and streams one packed row per valid/ready beat.
module acc_drain_quant
    import acc_drain_quant_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          rows_m1,
    input  logic [SCALE_WIDTH-1:0]         scale,
    input  logic [SHIFT_WIDTH-1:0]         shift,
    input  logic [OUT_WIDTH-1:0]           zero_point,
    output logic [ADDR_WIDTH-1:0]          acc_addr,
    input  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_vec,
    output logic [ARRAY_COL*OUT_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]          out_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  acc_addr_q;
    logic                   busy_q;
    logic                   done_q;
    logic [ADDR_WIDTH-1:0]  rows_m1_q;
    logic [SCALE_WIDTH-1:0] scale_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [OUT_WIDTH-1:0]   zp_q;

    logic                           s1_valid_q;
    logic [ADDR_WIDTH-1:0]          s1_row_q;
    logic [ARRAY_COL*ACC_WIDTH-1:0] s1_vec_q;
    logic                           s2_valid_q;
    logic [ADDR_WIDTH-1:0]          s2_row_q;
    logic                           out_valid_q;
    logic [ADDR_WIDTH-1:0]          out_row_q;

    logic stall;
    logic adv;
    logic issue_v;
    logic drained;

    assign stall   = out_valid_q && !out_ready;
    assign adv     = !stall;
    assign issue_v = (state_q == ST_ISSUE);
    // Last beat may be handshaking this very cycle with nothing behind it.
    assign drained = !s1_valid_q && !s2_valid_q &&
                     (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rows_m1_q  <= '0;
            scale_q    <= '0;
            shift_q    <= '0;
            zp_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rows_m1_q  <= rows_m1;
                        scale_q    <= scale;
                        shift_q    <= shift;
                        zp_q       <= zero_point;
                        acc_addr_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (adv) begin
                        if (acc_addr_q == rows_m1_q) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            acc_addr_q <= acc_addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drained) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_row_q    <= '0;
            s1_vec_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_row_q    <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else if (adv) begin
            s1_valid_q  <= issue_v;
            s1_row_q    <= acc_addr_q;
            s1_vec_q    <= acc_vec;
            s2_valid_q  <= s1_valid_q;
            s2_row_q    <= s1_row_q;
            out_valid_q <= s2_valid_q;
            out_row_q   <= s2_row_q;
        end
    end

    for (genvar c = 0; c < ARRAY_COL; c++) begin : g_lane
        requant_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .acc_i   (s1_vec_q[c*ACC_WIDTH +: ACC_WIDTH]),
            .scale_i (scale_q),
            .shift_i (shift_q),
            .zp_i    (zp_q),
            .q_o     (out_data[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    assign acc_addr  = acc_addr_q;
    assign out_row   = out_row_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_acc_drain_quant.sv
// Scoreboard bench for acc_drain_quant: a behavioural bank, a 64-bit
// requant model and a handshake monitor popping expected rows.
module tb_acc_drain_quant;

    typedef struct {
        logic [3:0]   row;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   rows_m1 = '0;
    logic [15:0]  scale = '0;
    logic [4:0]   shift = '0;
    logic [7:0]   zero_point = '0;
    logic [3:0]   acc_addr;
    logic [511:0] acc_vec;
    logic [127:0] out_data;
    logic [3:0]   out_row;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         done;

    logic [511:0] mem [16];
    exp_t         expq [$];

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int cur_rows = 0;
    logic         pend = 1'b0;
    logic [127:0] pend_data;
    logic [3:0]   pend_row;
    logic         prev_hs = 1'b0;
    logic [127:0] last_data = '0;

    acc_drain_quant dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rows_m1    (rows_m1),
        .scale      (scale),
        .shift      (shift),
        .zero_point (zero_point),
        .acc_addr   (acc_addr),
        .acc_vec    (acc_vec),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    assign acc_vec = mem[acc_addr];

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rq(input logic signed [31:0] a,
                                      input logic signed [15:0] s,
                                      input int sh,
                                      input logic signed [7:0] zp);
        longint p, r, q;
        p = longint'(a) * longint'(s);
        if (sh > 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
        else r = p;
        q = r + longint'(zp);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [127:0] model_row(input int r, input int sc,
                                               input int sh, input int zp);
        logic [127:0] d;
        logic [511:0] v;
        v = mem[r];
        for (int c = 0; c < 16; c++)
            d[c*8 +: 8] = rq($signed(v[c*32 +: 32]), 16'(sc), sh, 8'(zp));
        return d;
    endfunction

    task automatic fill_rand(input int span);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c*32 +: 32] = 32'($urandom_range(0, 2 * span) - span);
    endtask

    task automatic start_drain(input int rows, input int sc, input int sh,
                               input int zp);
        exp_t e;
        @(posedge clk); #1;
        rows_m1 = 4'(rows);
        scale = 16'(sc);
        shift = 5'(sh);
        zero_point = 8'(zp);
        start = 1'b1;
        cur_rows = rows;
        hs_cnt = 0;
        for (int r = 0; r <= rows; r++) begin
            e.row = 4'(r);
            e.data = model_row(r, sc, sh & 31, zp);
            expq.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic ignored_start(input int rows, input int sc);
        @(posedge clk); #1;
        rows_m1 = 4'(rows);
        scale = 16'(sc);
        shift = 5'd0;
        zero_point = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int rows, input int maxc);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt - base, 1);
        chk("beats", hs_cnt, rows + 1);
        chk("q_empty", expq.size(), 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else out_ready = 1'($urandom_range(0, 1));
    end

    initial forever begin
        exp_t e;
        logic hs;
        @(negedge clk);
        hs = 1'b0;
        if (!rst) begin
            if (pend) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pend_data);
                chk("stall_row", out_row, pend_row);
                pend = 1'b0;
            end
            if (busy) chk("addr_bound", acc_addr <= 4'(cur_rows), 1);
            if (done) begin
                done_cnt++;
                chk("done_timing", prev_hs, 1);
                chk("done_busy", busy, 0);
                chk("done_qempty", expq.size(), 0);
            end
            if (out_valid && out_ready) begin
                hs = 1'b1;
                hs_cnt++;
                last_data = out_data;
                chk("beat_expected", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("row", out_row, e.row);
                    chk("data", out_data, e.data);
                end
            end else if (out_valid) begin
                pend = 1'b1;
                pend_data = out_data;
                pend_row = out_row;
            end
        end
        prev_hs = hs;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        for (int r = 0; r < 16; r++) mem[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", acc_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        rst = 1'b0;

        // Basic pass-through with latency check
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mem[r][c*32 +: 32] = 32'(r * 16 + c);
        rdy_mode = 0;
        start_drain(3, 1, 0, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            if (!out_valid) lat++;
        end
        chk("latency", lat, 3);
        wait_done(3, 60);
        chk("basic_last", last_data[7:0], 8'd48);

        // Rounding, scale, saturation and zero-point on single-row drains
        fill_rand(100000);
        mem[0][0*32 +: 32] = 32'd1000;
        mem[0][1*32 +: 32] = -32'sd37;
        mem[0][2*32 +: 32] = 32'd6;
        mem[0][3*32 +: 32] = -32'sd100000;
        mem[0][4*32 +: 32] = 32'd50;
        mem[0][5*32 +: 32] = -32'sd20;
        start_drain(0, 3, 4, 0);
        wait_done(0, 40);
        chk("rnd_sat_hi", last_data[0*8 +: 8], 8'h7f);
        start_drain(0, 1, 2, 0);
        wait_done(0, 40);
        chk("rnd_neg", last_data[1*8 +: 8], 8'hf7);
        chk("rnd_pos", last_data[2*8 +: 8], 8'h02);
        start_drain(0, 1, 0, 0);
        wait_done(0, 40);
        chk("sat_lo", last_data[3*8 +: 8], 8'h80);
        start_drain(0, 1, 0, 100);
        wait_done(0, 40);
        chk("zp_sat", last_data[4*8 +: 8], 8'h7f);
        start_drain(0, 1, 0, -5);
        wait_done(0, 40);
        chk("zp_neg", last_data[5*8 +: 8], 8'he7);

        // Backpressure over the full bank
        fill_rand(200);
        rdy_mode = 1;
        start_drain(15, 7, 3, -2);
        wait_done(15, 400);
        fill_rand(1 << 30);
        start_drain(15, -12345, 31, 17);
        wait_done(15, 400);
        fill_rand(5000);
        start_drain(9, 321, 9, -60);
        wait_done(9, 300);

        // Start during busy must not disturb the drain
        fill_rand(300);
        start_drain(7, 5, 1, 3);
        repeat (3) @(negedge clk);
        ignored_start(2, -77);
        wait_done(7, 300);

        // Asynchronous reset mid-drain
        rdy_mode = 0;
        fill_rand(100);
        start_drain(15, 1, 0, 0);
        n = 0;
        while (!(out_valid && out_row == 4'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_row5", out_row, 5);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", acc_addr, 0);
        chk("arst_data", out_data, 0);
        expq.delete();
        pend = 1'b0;
        n = done_cnt;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_rst", done_cnt - n, 0);
        start_drain(3, 2, 1, 1);
        wait_done(3, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
